mem_bus_arbiter: RTL and testbench

Sequential arbiter and access controller for the single shared memory bus of the MIPS CPU. It takes requests from the instruction-fetch port and the load/store data port and grants them round-robin. It decodes the granted address into the program-memory window (CS_P) or the data-memory window (CS_D), applies a fixed number of wait states, and returns read data with a one-cycle acknowledge. Unmapped or illegal accesses complete with an error flag instead of a chip select.

---
 rtl/mem_bus_pkg.sv | 24 ++
 rtl/addr_window_decode.sv | 15 +
 rtl/mem_bus_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and default window bounds for the MIPS shared memory bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    localparam logic [31:0] PROG_BASE_DEF   = 32'h0000_1E10;
    localparam logic [31:0] PROG_LAST_DEF   = 32'h0000_220F;
    localparam logic [31:0] DATA_BASE_DEF   = 32'h0000_2210;
    localparam logic [31:0] DATA_LAST_DEF   = 32'h0000_260F;
    localparam int          WAIT_CYCLES_DEF = 2;
    localparam int          CNT_W           = 4;

endpackage

// File: rtl/addr_window_decode.sv
// Inclusive unsigned address-window hit detector.
// Latency: combinational.
// Backpressure: none.
// Ports: addr_i - address under test; hit_o - 1 when BASE <= addr_i <= LAST.
module addr_window_decode #(
    parameter logic [31:0] BASE = 32'h0,
    parameter logic [31:0] LAST = 32'h0
) (
    input  logic [31:0] addr_i,
    output logic        hit_o
);

    assign hit_o = (addr_i >= BASE) && (addr_i <= LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter/access controller for the shared instruction/data memory bus.
// Latency: legal access acks WAIT_CYCLES+2 cycles after grant edge; illegal access acks 1 cycle after.
// Backpressure: one transfer in flight; requesters hold req until ack, no new grant until back in IDLE.
// Ports: CLK/rst_n; fetch port i_req/i_addr -> i_rdata/i_ack/i_err;
//        data port d_req/d_we/d_addr/d_wdata -> d_rdata/d_ack/d_err;
//        bus mem_addr/mem_wdata/mem_we/CS_P/CS_D <- mem_rdata. All outputs are registered.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter logic [31:0] PROG_BASE   = PROG_BASE_DEF,
    parameter logic [31:0] PROG_LAST   = PROG_LAST_DEF,
    parameter logic [31:0] DATA_BASE   = DATA_BASE_DEF,
    parameter logic [31:0] DATA_LAST   = DATA_LAST_DEF,
    parameter int          WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        CS_P,
    output logic        CS_D,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_CYCLES);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    port_t              last_grant_q, last_grant_d;
    port_t              port_q, port_d;
    logic               we_q, we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic               mem_we_q, mem_we_d;
    logic               cs_p_q, cs_p_d;
    logic               cs_d_q, cs_d_d;
    logic               i_ack_q, i_ack_d;
    logic               i_err_q, i_err_d;
    logic [31:0]        i_rdata_q, i_rdata_d;
    logic               d_ack_q, d_ack_d;
    logic               d_err_q, d_err_d;
    logic [31:0]        d_rdata_q, d_rdata_d;

    // Candidate grant: D wins a tie only when I was served last.
    port_t              gnt_port;
    logic [31:0]        gnt_addr;
    logic [31:0]        gnt_wdata;
    logic               gnt_we;
    logic               gnt_legal;
    logic               hit_p;
    logic               hit_d;

    assign gnt_port  = (d_req && (!i_req || (last_grant_q == PORT_I))) ? PORT_D : PORT_I;
    assign gnt_addr  = (gnt_port == PORT_D) ? d_addr  : i_addr;
    assign gnt_wdata = (gnt_port == PORT_D) ? d_wdata : 32'h0;
    assign gnt_we    = (gnt_port == PORT_D) && d_we;

    // Decoding happens on the address being latched so that CS and the
    // error ack can both be registered on the grant edge itself.
    addr_window_decode #(.BASE(PROG_BASE), .LAST(PROG_LAST)) u_dec_prog (
        .addr_i (gnt_addr),
        .hit_o  (hit_p)
    );

    addr_window_decode #(.BASE(DATA_BASE), .LAST(DATA_LAST)) u_dec_data (
        .addr_i (gnt_addr),
        .hit_o  (hit_d)
    );

    // Fetches must hit program memory; data port may read either window
    // but may only write the data window.
    assign gnt_legal = (gnt_port == PORT_I) ? hit_p : (hit_d || (hit_p && !gnt_we));

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= PORT_I;
            port_q       <= PORT_I;
            we_q         <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            cs_p_q       <= 1'b0;
            cs_d_q       <= 1'b0;
            i_ack_q      <= 1'b0;
            i_err_q      <= 1'b0;
            i_rdata_q    <= '0;
            d_ack_q      <= 1'b0;
            d_err_q      <= 1'b0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            we_q         <= we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            cs_p_q       <= cs_p_d;
            cs_d_q       <= cs_d_d;
            i_ack_q      <= i_ack_d;
            i_err_q      <= i_err_d;
            i_rdata_q    <= i_rdata_d;
            d_ack_q      <= d_ack_d;
            d_err_q      <= d_err_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        we_d         = we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cs_p_d       = cs_p_q;
        cs_d_d       = cs_d_q;
        mem_we_d     = 1'b0;
        i_ack_d      = 1'b0;
        i_err_d      = 1'b0;
        i_rdata_d    = '0;
        d_ack_d      = 1'b0;
        d_err_d      = 1'b0;
        d_rdata_d    = '0;

        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    port_d       = gnt_port;
                    last_grant_d = gnt_port;
                    we_d         = gnt_we;
                    mem_addr_d   = gnt_addr;
                    mem_wdata_d  = gnt_wdata;
                    if (gnt_legal) begin
                        state_d  = ST_ACCESS;
                        cnt_d    = WAIT_CNT;
                        cs_p_d   = hit_p;
                        cs_d_d   = hit_d;
                        // With zero wait states the first ACCESS cycle is also the last.
                        mem_we_d = gnt_we && (WAIT_CNT == '0);
                    end else begin
                        state_d  = ST_RESP;
                        i_ack_d  = (gnt_port == PORT_I);
                        i_err_d  = (gnt_port == PORT_I);
                        d_ack_d  = (gnt_port == PORT_D);
                        d_err_d  = (gnt_port == PORT_D);
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    cs_p_d  = 1'b0;
                    cs_d_d  = 1'b0;
                    if (port_q == PORT_I) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = mem_rdata;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = we_q ? 32'h0 : mem_rdata;
                    end
                end else begin
                    cnt_d    = cnt_q - 1'b1;
                    // Registered strobe: raise it for the cycle in which cnt reaches 0.
                    mem_we_d = we_q && (cnt_q == CNT_W'(1));
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign i_rdata   = i_rdata_q;
    assign i_ack     = i_ack_q;
    assign i_err     = i_err_q;
    assign d_rdata   = d_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_err     = d_err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign CS_P      = cs_p_q;
    assign CS_D      = cs_d_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed cases then randomized transfers
// against a transaction-level model of grant order, window legality and timing.
module tb_mem_bus_arbiter;

    localparam logic [31:0] PB = 32'h0000_1E10;
    localparam logic [31:0] PL = 32'h0000_220F;
    localparam logic [31:0] DB = 32'h0000_2210;
    localparam logic [31:0] DL = 32'h0000_260F;
    localparam int          W  = 2;

    logic        CLK;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        CS_P;
    logic        CS_D;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;
    int m_last = 0;  // model of last served port: 0 = I, 1 = D

    mem_bus_arbiter #(
        .PROG_BASE   (PB),
        .PROG_LAST   (PL),
        .DATA_BASE   (DB),
        .DATA_LAST   (DL),
        .WAIT_CYCLES (W)
    ) dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ack     (i_ack),
        .i_err     (i_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .d_err     (d_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .CS_P      (CS_P),
        .CS_D      (CS_D),
        .mem_rdata (mem_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".i_ack"},     32'(i_ack),   32'h0);
        chk({tag, ".i_err"},     32'(i_err),   32'h0);
        chk({tag, ".d_ack"},     32'(d_ack),   32'h0);
        chk({tag, ".d_err"},     32'(d_err),   32'h0);
        chk({tag, ".CS_P"},      32'(CS_P),    32'h0);
        chk({tag, ".CS_D"},      32'(CS_D),    32'h0);
        chk({tag, ".mem_we"},    32'(mem_we),  32'h0);
        chk({tag, ".mem_addr"},  mem_addr,     32'h0);
        chk({tag, ".mem_wdata"}, mem_wdata,    32'h0);
        chk({tag, ".i_rdata"},   i_rdata,      32'h0);
        chk({tag, ".d_rdata"},   d_rdata,      32'h0);
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0:       a = PB;
            1:       a = PL;
            2:       a = DB;
            3:       a = DL;
            4:       a = PB - 32'd1;
            5:       a = DL + 32'd1;
            6, 7:    a = PB + 32'($urandom_range(0, 1023));
            8:       a = DB + 32'($urandom_range(0, 1023));
            default: a = $urandom;
        endcase
        return a;
    endfunction

    // New request on a port; p_off is the percentage chance it stays idle.
    task automatic new_req(input int port, input int p_off);
        logic go;
        go = ($urandom_range(0, 99) >= p_off);
        if (port == 0) begin
            i_req  = go;
            i_addr = pick_addr();
        end else begin
            d_req   = go;
            d_addr  = pick_addr();
            d_we    = 1'($urandom_range(0, 1));
            d_wdata = $urandom;
        end
    endtask

    // Entered at a negedge in IDLE with inputs already set; returns at the
    // negedge of the IDLE cycle that follows the response.
    // after_mode: 0 winner drops req, 1 winner re-requests same, 2 random new.
    task automatic do_transfer(input int after_mode);
        int          win;
        logic [31:0] a, wd, rd, exp_rd;
        logic        we, in_p, in_d, legal;

        win    = (i_req && d_req) ? ((m_last == 0) ? 1 : 0) : (d_req ? 1 : 0);
        m_last = win;
        a      = (win == 1) ? d_addr : i_addr;
        we     = (win == 1) ? d_we : 1'b0;
        wd     = d_wdata;
        in_p   = (a >= PB) && (a <= PL);
        in_d   = (a >= DB) && (a <= DL);
        legal  = (win == 0) ? in_p : (in_d || (in_p && !we));
        rd     = 32'h0;

        @(posedge CLK);
        @(negedge CLK);
        if (legal) begin
            for (int k = 1; k <= W + 1; k++) begin
                chk("acc.CS_P",     32'(CS_P),   32'(in_p));
                chk("acc.CS_D",     32'(CS_D),   32'(in_d));
                chk("acc.mem_addr", mem_addr,    a);
                chk("acc.mem_we",   32'(mem_we), 32'(we && (k == W + 1)));
                if (we) chk("acc.mem_wdata", mem_wdata, wd);
                chk("acc.i_ack",    32'(i_ack),  32'h0);
                chk("acc.d_ack",    32'(d_ack),  32'h0);
                // Winner may scramble its inputs after grant; the DUT must ignore it.
                if (k == 1 && after_mode == 2 && $urandom_range(0, 3) == 0) begin
                    if (win == 0) begin
                        i_req  = 1'b0;
                        i_addr = $urandom;
                    end else begin
                        d_req   = 1'b0;
                        d_addr  = $urandom;
                        d_we    = ~d_we;
                        d_wdata = $urandom;
                    end
                end
                mem_rdata = $urandom;
                rd        = mem_rdata;
                @(negedge CLK);
            end
        end

        exp_rd = (legal && !we) ? rd : 32'h0;
        chk("resp.i_ack",   32'(i_ack),  32'(win == 0));
        chk("resp.d_ack",   32'(d_ack),  32'(win == 1));
        chk("resp.i_err",   32'(i_err),  32'(win == 0 && !legal));
        chk("resp.d_err",   32'(d_err),  32'(win == 1 && !legal));
        chk("resp.i_rdata", i_rdata,     (win == 0) ? exp_rd : 32'h0);
        chk("resp.d_rdata", d_rdata,     (win == 1) ? exp_rd : 32'h0);
        chk("resp.CS_P",    32'(CS_P),   32'h0);
        chk("resp.CS_D",    32'(CS_D),   32'h0);
        chk("resp.mem_we",  32'(mem_we), 32'h0);

        if (after_mode == 0) begin
            if (win == 0) i_req = 1'b0; else d_req = 1'b0;
        end else if (after_mode == 1) begin
            if (win == 0) begin
                i_req  = 1'b1;
                i_addr = a;
            end else begin
                d_req   = 1'b1;
                d_addr  = a;
                d_we    = we;
                d_wdata = wd;
            end
        end else begin
            new_req(win, 30);
        end

        @(negedge CLK);
        chk("idle.i_ack", 32'(i_ack), 32'h0);
        chk("idle.d_ack", 32'(d_ack), 32'h0);
        chk("idle.CS_P",  32'(CS_P),  32'h0);
        chk("idle.CS_D",  32'(CS_D),  32'h0);
    endtask

    initial begin
        rst_n     = 1'b0;
        i_req     = 1'b0;
        i_addr    = 32'h0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = 32'h0;
        d_wdata   = 32'h0;
        mem_rdata = 32'h0;

        repeat (2) @(negedge CLK);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge CLK);

        // Fetch at start of program window.
        i_req = 1'b1; i_addr = PB;
        do_transfer(0);

        // Data write at start of data window.
        d_req = 1'b1; d_we = 1'b1; d_addr = DB; d_wdata = 32'hDEAD_BEEF;
        do_transfer(0);

        // Fresh reset, then both ports held: D, I, D, I.
        rst_n = 1'b0;
        @(negedge CLK);
        m_last = 0;
        rst_n = 1'b1;
        @(negedge CLK);
        i_req = 1'b1; i_addr = PB + 32'd4;
        d_req = 1'b1; d_we = 1'b0; d_addr = DB + 32'd8;
        repeat (4) do_transfer(1);
        i_req = 1'b0; d_req = 1'b0;
        @(negedge CLK);

        // Window boundaries.
        i_req = 1'b1; i_addr = PL;            do_transfer(0);
        i_req = 1'b1; i_addr = DB;            do_transfer(0);
        d_req = 1'b1; d_we = 1'b1; d_addr = PB; do_transfer(0);
        d_req = 1'b1; d_we = 1'b0; d_addr = DL + 32'd1; do_transfer(0);

        // Reset while in ACCESS.
        i_req = 1'b1; i_addr = PB + 32'd16;
        @(posedge CLK);
        @(negedge CLK);
        chk("rstmid.CS_P_before", 32'(CS_P), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_zero("rstmid");
        i_req = 1'b0;
        @(negedge CLK);
        rst_n  = 1'b1;
        m_last = 0;
        repeat (W + 3) begin
            @(negedge CLK);
            chk("rstmid.no_i_ack", 32'(i_ack), 32'h0);
            chk("rstmid.no_d_ack", 32'(d_ack), 32'h0);
        end
        i_req = 1'b1; i_addr = PB + 32'd8;
        do_transfer(0);

        // Randomized traffic.
        repeat (150) begin
            if (!i_req) new_req(0, 50);
            if (!d_req) new_req(1, 50);
            if (!i_req && !d_req) new_req($urandom_range(0, 1), 0);
            do_transfer(2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
